// File: rtl/gop_16.sv
// gop_16: board controller that runs one fixed I2C master write after reset.
// Sequence: START, {SLAVE_ADDR,W}, REG_ADDR, WR_DATA (each followed by an ACK bit), STOP.
// A NACK on any byte skips the remaining bytes and goes straight to STOP.
// Ports:
//   phi0    in     system clock, rising edge
//   res     in     synchronous active-high reset
//   SDA     inout  I2C data, open-drain (drives 0 or releases)
//   SCL     out    I2C clock, push-pull
//   userled out    [7]=busy [6]=done [5]=nack [4:3]=byte index [2:0]=0
module gop_16 #(
  parameter int unsigned CLK_DIV    = 4,
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter logic [7:0]  REG_ADDR   = 8'h00,
  parameter logic [7:0]  WR_DATA    = 8'hA5
) (
  input  logic       phi0,
  input  logic       res,
  inout  wire        SDA,
  output logic       SCL,
  output logic [7:0] userled
);

  localparam int unsigned    DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    StIdleRst,
    StStart,
    StBit,
    StStop,
    StDone
  } state_e;

  state_e          r_state, w_state_d;
  logic [DivW-1:0] r_div, w_div_d;
  logic [1:0]      r_qtr, w_qtr_d;
  logic [3:0]      r_bit, w_bit_d;   // 0..7 data bits, 8 = ACK bit
  logic [1:0]      r_byte, w_byte_d;
  logic            r_ack, w_ack_d;
  logic            r_nack, w_nack_d;
  logic            r_scl, w_scl_d;
  logic            r_sda_oe, w_sda_oe_d;
  logic [7:0]      r_led, w_led_d;

  logic            w_qend;
  logic [7:0]      w_tx_byte;
  logic            w_tx_bit;
  logic            w_busy;
  logic            w_done;

  assign w_qend = (r_div == DivLast);

  // Next-state: counters advance once per quarter; the FSM moves on quarter boundaries.
  always_comb begin
    w_state_d = r_state;
    w_div_d   = r_div;
    w_qtr_d   = r_qtr;
    w_bit_d   = r_bit;
    w_byte_d  = r_byte;
    w_ack_d   = r_ack;
    w_nack_d  = r_nack;

    if (r_state != StIdleRst && r_state != StDone) begin
      w_div_d = w_qend ? '0 : r_div + DivW'(1);
    end

    unique case (r_state)
      StIdleRst: begin
        w_state_d = StStart;
        w_div_d   = '0;
        w_qtr_d   = 2'd0;
      end
      StStart: begin
        if (w_qend) begin
          if (r_qtr == 2'd1) begin
            w_state_d = StBit;
            w_qtr_d   = 2'd0;
            w_bit_d   = 4'd0;
            w_byte_d  = 2'd0;
          end else begin
            w_qtr_d = r_qtr + 2'd1;
          end
        end
      end
      StBit: begin
        // Sample the slave's ACK on the last clock of Q2 of the ACK bit; Z/X read as NACK.
        if (w_qend && r_bit == 4'd8 && r_qtr == 2'd2) begin
          w_ack_d = 1'b0;
          if (SDA == 1'b0) w_ack_d = 1'b1;
        end
        if (w_qend) begin
          w_qtr_d = r_qtr + 2'd1;
          if (r_qtr == 2'd3) begin
            if (r_bit != 4'd8) begin
              w_bit_d = r_bit + 4'd1;
            end else if (r_ack && r_byte != 2'd2) begin
              w_bit_d  = 4'd0;
              w_byte_d = r_byte + 2'd1;
            end else begin
              w_state_d = StStop;
              w_nack_d  = r_nack | ~r_ack;
            end
          end
        end
      end
      StStop: begin
        if (w_qend) begin
          if (r_qtr == 2'd2) begin
            w_state_d = StDone;
            w_qtr_d   = 2'd0;
          end else begin
            w_qtr_d = r_qtr + 2'd1;
          end
        end
      end
      StDone: begin
      end
      default: begin
        w_state_d = StIdleRst;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so pins change on the
  // same edge that starts a quarter.
  always_comb begin
    unique case (w_byte_d)
      2'd0:    w_tx_byte = {SLAVE_ADDR, 1'b0};
      2'd1:    w_tx_byte = REG_ADDR;
      default: w_tx_byte = WR_DATA;
    endcase
    w_tx_bit = w_tx_byte[3'd7 - w_bit_d[2:0]];

    w_scl_d    = 1'b1;
    w_sda_oe_d = 1'b0;
    unique case (w_state_d)
      StStart: w_sda_oe_d = (w_qtr_d == 2'd1);
      StBit: begin
        w_scl_d    = w_qtr_d[1];
        w_sda_oe_d = (w_bit_d != 4'd8) && !w_tx_bit;
      end
      StStop: begin
        w_scl_d    = (w_qtr_d != 2'd0);
        w_sda_oe_d = (w_qtr_d != 2'd2);
      end
      default: begin
      end
    endcase

    w_busy  = (w_state_d == StStart) || (w_state_d == StBit) || (w_state_d == StStop);
    w_done  = (w_state_d == StDone);
    w_led_d = {w_busy, w_done, w_nack_d, w_byte_d, 3'b000};
  end

  always_ff @(posedge phi0) begin
    if (res) begin
      r_state  <= StIdleRst;
      r_div    <= '0;
      r_qtr    <= 2'd0;
      r_bit    <= 4'd0;
      r_byte   <= 2'd0;
      r_ack    <= 1'b0;
      r_nack   <= 1'b0;
      r_scl    <= 1'b1;
      r_sda_oe <= 1'b0;
      r_led    <= 8'h00;
    end else begin
      r_state  <= w_state_d;
      r_div    <= w_div_d;
      r_qtr    <= w_qtr_d;
      r_bit    <= w_bit_d;
      r_byte   <= w_byte_d;
      r_ack    <= w_ack_d;
      r_nack   <= w_nack_d;
      r_scl    <= w_scl_d;
      r_sda_oe <= w_sda_oe_d;
      r_led    <= w_led_d;
    end
  end

  assign SDA     = r_sda_oe ? 1'b0 : 1'bz;
  assign SCL     = r_scl;
  assign userled = r_led;

endmodule

// File: tb/tb_gop_16.sv
// Bench for gop_16: a bus-level slave/decoder checks decoded bytes, ACK handling,
// done latency, START/STOP events, SCL periods and the LED status word.
module tb_gop_16;

  localparam int unsigned ClkDiv = 4;

  logic       phi0 = 1'b0;
  logic       res  = 1'b1;
  wire        SDA;
  logic       SCL;
  logic [7:0] userled;
  logic       s_pull = 1'b0;

  pullup (SDA);
  assign SDA = s_pull ? 1'b0 : 1'bz;

  gop_16 #(
    .CLK_DIV(ClkDiv)
  ) dut (
    .phi0   (phi0),
    .res    (res),
    .SDA    (SDA),
    .SCL    (SCL),
    .userled(userled)
  );

  always #5 phi0 = ~phi0;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc   = 0;
  logic       p_scl = 1'b1;
  logic       p_sda = 1'b1;
  int         n_start, n_stop;
  int         s_bits, s_byte;
  logic [7:0] s_shift;
  logic [2:0] s_mask;
  logic [7:0] q_bytes[$];
  int         rises[$];
  logic [7:0] exp_bytes[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample the bus 1ns after the edge and run the slave/monitor.
  task automatic tick();
    logic sc, sd;
    @(posedge phi0);
    #1;
    cyc++;
    sc = SCL;
    sd = SDA;
    if (p_scl && sc && p_sda && !sd) begin
      n_start++;
      s_bits = 0;
      s_byte = 0;
      s_pull = 1'b0;
    end
    if (p_scl && sc && !p_sda && sd) n_stop++;
    if (!p_scl && sc) begin
      rises.push_back(cyc);
      if (s_bits < 8) begin
        s_shift = {s_shift[6:0], sd};
        s_bits++;
        if (s_bits == 8) q_bytes.push_back(s_shift);
      end else begin
        s_bits++;
      end
    end
    if (p_scl && !sc) begin
      if (s_bits == 8 && s_byte < 3 && s_mask[s_byte]) begin
        s_pull = 1'b1;
      end else if (s_bits == 9) begin
        s_pull = 1'b0;
        s_bits = 0;
        s_byte++;
      end
    end
    p_scl = sc;
    p_sda = sd;
  endtask

  // Hold reset, release it, then follow one transaction. abort_at >= 0 re-asserts
  // reset at that clock (clock 0 = first edge with res low).
  task automatic run(input string nm, input logic [2:0] mask, input int abort_at);
    int         nb, lat, done_e, bad_low, bad_both, bad_hold, bad_per;
    logic       nack;
    logic [7:0] exp_led;

    res    = 1'b1;
    s_pull = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk({nm, ".rst_scl"}, 32'(SCL), 32'd1);
      chk({nm, ".rst_sda"}, 32'(SDA), 32'd1);
      chk({nm, ".rst_led"}, 32'(userled), 32'h00);
    end

    // Expected outcome straight from the protocol rules.
    nb   = 3;
    nack = 1'b0;
    for (int k = 2; k >= 0; k--) begin
      if (!mask[k]) begin
        nb   = k + 1;
        nack = 1'b1;
      end
    end
    lat     = (2 + 36 * nb + 3) * ClkDiv;
    exp_led = {2'b01, nack, 2'(nb - 1), 3'b000};

    s_mask  = mask;
    n_start = 0;
    n_stop  = 0;
    s_bits  = 0;
    s_byte  = 0;
    q_bytes.delete();
    rises.delete();
    done_e   = -1;
    bad_low  = 0;
    bad_both = 0;
    bad_hold = 0;
    res      = 1'b0;

    for (int e = 1; e <= lat + 20; e++) begin
      tick();
      if (e == 1) chk({nm, ".first_led"}, 32'(userled), 32'h80);
      if (userled[2:0] !== 3'b000) bad_low++;
      if (userled[7] && userled[6]) bad_both++;
      if (done_e < 0 && userled[6] === 1'b1) done_e = e;
      if (done_e > 0 && (userled !== exp_led || SCL !== 1'b1 || SDA !== 1'b1)) bad_hold++;
      if (abort_at >= 0 && e - 1 == abort_at) begin
        res    = 1'b1;
        s_pull = 1'b0;
        tick();
        chk({nm, ".abort_scl"}, 32'(SCL), 32'd1);
        chk({nm, ".abort_sda"}, 32'(SDA), 32'd1);
        chk({nm, ".abort_led"}, 32'(userled), 32'h00);
        chk({nm, ".abort_low"}, 32'(bad_low), 32'd0);
        return;
      end
    end

    chk({nm, ".latency"}, 32'(done_e - 1), 32'(lat));
    chk({nm, ".led_final"}, 32'(userled), 32'(exp_led));
    chk({nm, ".led_low"}, 32'(bad_low), 32'd0);
    chk({nm, ".busy_done"}, 32'(bad_both), 32'd0);
    chk({nm, ".hold"}, 32'(bad_hold), 32'd0);
    chk({nm, ".starts"}, 32'(n_start), 32'd1);
    chk({nm, ".stops"}, 32'(n_stop), 32'd1);
    chk({nm, ".nbytes"}, 32'(q_bytes.size()), 32'(nb));
    for (int i = 0; i < nb && i < q_bytes.size(); i++) begin
      chk({nm, ".byte"}, 32'(q_bytes[i]), 32'(exp_bytes[i]));
    end
    // SCL rises every bit (one quarter-set of 4) and once more in STOP, 3 quarters later.
    chk({nm, ".rises"}, 32'(rises.size()), 32'(9 * nb + 1));
    bad_per = 0;
    for (int i = 1; i < rises.size(); i++) begin
      if (i == rises.size() - 1) begin
        if (rises[i] - rises[i-1] != 3 * ClkDiv) bad_per++;
      end else if (rises[i] - rises[i-1] != 4 * ClkDiv) begin
        bad_per++;
      end
    end
    chk({nm, ".scl_period"}, 32'(bad_per), 32'd0);
  endtask

  initial begin
    int           ab;
    logic [2:0]   m;
    exp_bytes[0] = 8'hA0;
    exp_bytes[1] = 8'h00;
    exp_bytes[2] = 8'hA5;

    run("float", 3'b000, -1);
    run("all_ack", 3'b111, -1);
    run("nack_data", 3'b011, -1);
    run("nack_reg", 3'b001, -1);
    run("abort100", 3'b111, 100);
    run("restart", 3'b111, -1);
    for (int r = 0; r < 6; r++) begin
      m  = 3'($urandom);
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(10, 150)) : -1;
      run("rand", m, ab);
    end
    run("final", 3'b111, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
